uart_tx_arbiter: RTL

Shares one UART transmitter (tx_start / tx_done_tick / d_in handshake) among NREQ requesters.

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx core among NREQ packet streams.
// Packets are atomic; the grant moves only on a last byte or an idle-hold timeout.
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int DBIT     = 8,
    parameter int HOLD_MAX = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      last,
    input  logic [NREQ*DBIT-1:0] din,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      grant,
    output logic                 tx_start,
    output logic [DBIT-1:0]      d_in,
    input  logic                 tx_done_tick,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   sel_q, sel_d;
    logic            last_q, last_d;
    logic [15:0]     hold_q, hold_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [DBIT-1:0] d_in_q, d_in_d;

    logic [DBIT-1:0] din_a [NREQ];
    logic [PW-1:0]   idx;
    logic [PW-1:0]   pick;
    logic            pick_valid;
    logic [PW-1:0]   sel_inc;

    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            din_a[i] = din[i*DBIT +: DBIT];
        end
    end

    // First requester at or above ptr, wrapping modulo NREQ.
    always_comb begin
        idx        = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PW'((32'(ptr_q) + k) % NREQ);
            if (!pick_valid && req[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    assign sel_inc = (sel_q == PW'(NREQ - 1)) ? '0 : sel_q + PW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            last_q  <= 1'b0;
            hold_q  <= '0;
            grant_q <= '0;
            d_in_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            d_in_q  <= d_in_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        last_d  = last_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        d_in_d  = d_in_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    sel_d       = pick;
                    grant_d     = '0;
                    grant_d[pick] = 1'b1;
                    d_in_d      = din_a[pick];
                    last_d      = last[pick];
                    state_d     = LOAD;
                end
            end
            LOAD: state_d = WAIT;
            WAIT: begin
                if (tx_done_tick) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = sel_inc;
                        state_d = IDLE;
                    end else begin
                        hold_d  = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                // Release after HOLD_MAX consecutive idle cycles in HOLD.
                if (req[sel_q]) begin
                    d_in_d  = din_a[sel_q];
                    last_d  = last[sel_q];
                    state_d = LOAD;
                end else if (hold_q + 16'd1 == 16'(HOLD_MAX)) begin
                    hold_d  = '0;
                    grant_d = '0;
                    ptr_d   = sel_inc;
                    state_d = IDLE;
                end else begin
                    hold_d  = hold_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_start = (state_q == LOAD);
        busy     = (state_q != IDLE);
        ack      = '0;
        if (state_q == WAIT && tx_done_tick) begin
            ack[sel_q] = 1'b1;
        end
    end

    assign grant = grant_q;
    assign d_in  = d_in_q;

endmodule
